// File: rtl/rv_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control sequencer.
// Holds the state enum, opcode constants, datapath select codes and control word layout.
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_LUI,
        S_FAULT
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SLL = 3'b001;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_OR  = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b111;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctrl;
        logic [1:0] result_src;
        logic [2:0] imm_src;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    // Where DECODE goes next; an illegal encoding of a known opcode also lands in FAULT.
    function automatic state_t decode_target(input logic [6:0] opcode, input logic op_legal);
        state_t target;
        target = S_FAULT;
        case (opcode)
            OP_LOAD, OP_STORE: target = S_MEMADR;
            OP_RTYPE:          target = op_legal ? S_EXECR  : S_FAULT;
            OP_ITYPE:          target = op_legal ? S_EXECI  : S_FAULT;
            OP_BRANCH:         target = op_legal ? S_BRANCH : S_FAULT;
            OP_JAL:            target = S_JAL;
            OP_LUI:            target = S_LUI;
            default:           target = S_FAULT;
        endcase
        return target;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps funct3/funct7[5] to an ALU operation code and flags encodings this core does not support.
// Shared by the execute states and the legality check done during DECODE.
module alu_decoder
    import rv_ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       is_rtype,
    output logic [2:0] alu_ctrl,
    output logic       legal
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        legal    = 1'b1;
        case (funct3)
            3'b000:  alu_ctrl = ALU_ADD;
            3'b001:  alu_ctrl = ALU_SLL;
            3'b100:  alu_ctrl = ALU_XOR;
            3'b101:  alu_ctrl = ALU_SRL;
            3'b110:  alu_ctrl = ALU_OR;
            3'b111:  alu_ctrl = ALU_AND;
            default: legal    = 1'b0;
        endcase
        // sub/sra (R-type) and srai (I-type shift-right) need an ALU op we do not have
        if (funct7_5 && (is_rtype || funct3 == 3'b101)) begin
            legal = 1'b0;
        end
    end

endmodule

// File: rtl/rv_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: walks fetch/decode/execute/memory/writeback and
// drives the shared datapath strobes combinationally from state, instr and mem_ready.
module rv_ctrl_fsm
    import rv_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ALUCTRL_WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_WIDTH-1:0]    instr,
    input  logic                     mem_ready,
    input  logic                     ResultZero,
    output logic                     mem_req,
    output logic                     MemWrite,
    output logic                     AdrSrc,
    output logic                     IRwrite,
    output logic                     PCwrite,
    output logic                     RegWrite,
    output logic [1:0]               ALUsrcA,
    output logic [1:0]               ALUsrcB,
    output logic [ALUCTRL_WIDTH-1:0] ALUctrl,
    output logic [1:0]               ResultSrc,
    output logic [2:0]               ImmSrc,
    output logic                     illegal
);

    state_t state_reg;
    state_t state_next;
    ctrl_t  ctrl;
    ctrl_t  ctrl_out;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_rtype;
    logic       is_itype;
    logic       is_branch;
    logic       is_store;
    logic       is_jal;
    logic [2:0] dec_alu_ctrl;
    logic       dec_legal;
    logic       op_legal;
    logic       unused_bits;

    assign opcode    = instr[6:0];
    assign funct3    = instr[14:12];
    assign is_rtype  = (opcode == OP_RTYPE);
    assign is_itype  = (opcode == OP_ITYPE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_store  = (opcode == OP_STORE);
    assign is_jal    = (opcode == OP_JAL);

    assign unused_bits = ^{instr[DATA_WIDTH-1:31], instr[29:15], instr[11:7]};

    alu_decoder u_alu_decoder (
        .funct3   (funct3),
        .funct7_5 (instr[30]),
        .is_rtype (is_rtype),
        .alu_ctrl (dec_alu_ctrl),
        .legal    (dec_legal)
    );

    always_comb begin
        op_legal = 1'b1;
        if (is_rtype || is_itype) begin
            op_legal = dec_legal;
        end else if (is_branch) begin
            op_legal = (funct3[2:1] == 2'b00);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ctrl       = CTRL_IDLE;
        case (state_reg)
            S_FETCH: begin
                ctrl.mem_req = 1'b1;
                ctrl.adr_src = 1'b0;
                if (mem_ready) begin
                    ctrl.ir_write   = 1'b1;
                    ctrl.pc_write   = 1'b1;
                    ctrl.alu_src_a  = SRCA_PC;
                    ctrl.alu_src_b  = SRCB_FOUR;
                    ctrl.alu_ctrl   = ALU_ADD;
                    ctrl.result_src = RES_ALU;
                    state_next      = S_DECODE;
                end
            end
            S_DECODE: begin
                // oldPC + imm lands in ALUout so BRANCH/JAL can reuse it as the target
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_ctrl  = ALU_ADD;
                ctrl.imm_src   = is_jal ? IMM_J : IMM_B;
                state_next     = decode_target(opcode, op_legal);
            end
            S_MEMADR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_ctrl  = ALU_ADD;
                ctrl.imm_src   = is_store ? IMM_S : IMM_I;
                state_next     = is_store ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                ctrl.mem_req = 1'b1;
                ctrl.adr_src = 1'b1;
                if (mem_ready) begin
                    state_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                ctrl.result_src = RES_MEM;
                ctrl.reg_write  = 1'b1;
                state_next      = S_FETCH;
            end
            S_MEMWRITE: begin
                ctrl.mem_req   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.adr_src   = 1'b1;
                if (mem_ready) begin
                    state_next = S_FETCH;
                end
            end
            S_EXECR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_RS2;
                ctrl.alu_ctrl  = dec_alu_ctrl;
                state_next     = S_ALUWB;
            end
            S_EXECI: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.imm_src   = IMM_I;
                ctrl.alu_ctrl  = dec_alu_ctrl;
                state_next     = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_write  = 1'b1;
                state_next      = S_FETCH;
            end
            S_BRANCH: begin
                // xor of rs1/rs2 is zero exactly when the operands are equal
                ctrl.alu_src_a  = SRCA_RS1;
                ctrl.alu_src_b  = SRCB_RS2;
                ctrl.alu_ctrl   = ALU_XOR;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_write   = funct3[0] ? !ResultZero : ResultZero;
                state_next      = S_FETCH;
            end
            S_JAL: begin
                ctrl.alu_src_a  = SRCA_OLDPC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_ctrl   = ALU_ADD;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_write   = 1'b1;
                state_next      = S_ALUWB;
            end
            S_LUI: begin
                ctrl.alu_src_a = SRCA_ZERO;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.imm_src   = IMM_U;
                ctrl.alu_ctrl  = ALU_ADD;
                state_next     = S_ALUWB;
            end
            S_FAULT: begin
                ctrl.illegal = 1'b1;
                state_next   = S_FAULT;
            end
            default: begin
                state_next = S_FAULT;
            end
        endcase
    end

    // Gating with rst_n drops every strobe the instant reset is asserted, FETCH included.
    assign ctrl_out = rst_n ? ctrl : CTRL_IDLE;

    assign mem_req   = ctrl_out.mem_req;
    assign MemWrite  = ctrl_out.mem_write;
    assign AdrSrc    = ctrl_out.adr_src;
    assign IRwrite   = ctrl_out.ir_write;
    assign PCwrite   = ctrl_out.pc_write;
    assign RegWrite  = ctrl_out.reg_write;
    assign ALUsrcA   = ctrl_out.alu_src_a;
    assign ALUsrcB   = ctrl_out.alu_src_b;
    assign ALUctrl   = ALUCTRL_WIDTH'(ctrl_out.alu_ctrl);
    assign ResultSrc = ctrl_out.result_src;
    assign ImmSrc    = ctrl_out.imm_src;
    assign illegal   = ctrl_out.illegal;

    fault_sticky: assert property (@(posedge clk) disable iff (!rst_n)
        state_reg == S_FAULT |=> state_reg == S_FAULT);

    write_needs_req: assert property (@(posedge clk) disable iff (!rst_n)
        MemWrite |-> mem_req);

    ir_load_advances_pc: assert property (@(posedge clk) disable iff (!rst_n)
        IRwrite |-> PCwrite);

endmodule

// File: tb/tb_rv_ctrl_fsm.sv
// Randomized bench for rv_ctrl_fsm: an instruction-level model expands each instruction into
// its expected per-cycle control words, which are replayed against the DUT cycle by cycle.
module tb_rv_ctrl_fsm;

    localparam int DATA_WIDTH    = 32;
    localparam int ALUCTRL_WIDTH = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = '0;
    logic        mem_ready = 1'b0;
    logic        ResultZero = 1'b0;
    logic        mem_req, MemWrite, AdrSrc, IRwrite, PCwrite, RegWrite, illegal;
    logic [1:0]  ALUsrcA, ALUsrcB, ResultSrc;
    logic [2:0]  ALUctrl, ImmSrc;
    logic [18:0] observed;

    rv_ctrl_fsm #(.DATA_WIDTH(DATA_WIDTH), .ALUCTRL_WIDTH(ALUCTRL_WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .mem_ready  (mem_ready),
        .ResultZero (ResultZero),
        .mem_req    (mem_req),
        .MemWrite   (MemWrite),
        .AdrSrc     (AdrSrc),
        .IRwrite    (IRwrite),
        .PCwrite    (PCwrite),
        .RegWrite   (RegWrite),
        .ALUsrcA    (ALUsrcA),
        .ALUsrcB    (ALUsrcB),
        .ALUctrl    (ALUctrl),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    assign observed = {mem_req, MemWrite, AdrSrc, IRwrite, PCwrite, RegWrite,
                       ALUsrcA, ALUsrcB, ALUctrl, ResultSrc, ImmSrc, illegal};

    typedef struct {
        logic        rst_n;
        logic        mr;
        logic        rz;
        logic [31:0] ins;
        logic [18:0] exp;
        string       tag;
    } step_t;

    step_t steps[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    n_txn = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic bit coin();
        return 1'($urandom);
    endfunction

    function automatic logic [18:0] cw(input bit req, input bit wr, input bit adr, input bit irw,
                                       input bit pcw, input bit rw, input logic [1:0] a,
                                       input logic [1:0] b, input logic [2:0] alu,
                                       input logic [1:0] res, input logic [2:0] imm, input bit ill);
        return {req, wr, adr, irw, pcw, rw, a, b, alu, res, imm, ill};
    endfunction

    task automatic add_step(input bit rst, input bit mr, input bit rz, input logic [31:0] ins,
                            input logic [18:0] exp, input string tag);
        step_t s;
        s.rst_n = rst;
        s.mr    = mr;
        s.rz    = rz;
        s.ins   = ins;
        s.exp   = exp;
        s.tag   = tag;
        steps.push_back(s);
    endtask

    function automatic bit known_op(input logic [6:0] op);
        return op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 || op == 7'b0010011 ||
               op == 7'b1100011 || op == 7'b1101111 || op == 7'b0110111;
    endfunction

    // Which encodings the core accepts, straight from the instruction-set subset it supports.
    function automatic bit is_legal(input logic [31:0] ins);
        logic [2:0] f3;
        f3 = ins[14:12];
        case (ins[6:0])
            7'b0110011: return (f3 != 3'd2) && (f3 != 3'd3) && (ins[30] == 1'b0);
            7'b0010011: return (f3 != 3'd2) && (f3 != 3'd3) && !(f3 == 3'd5 && ins[30]);
            7'b1100011: return (f3 == 3'd0) || (f3 == 3'd1);
            default:    return known_op(ins[6:0]);
        endcase
    endfunction

    function automatic logic [2:0] alu_for(input logic [2:0] f3);
        case (f3)
            3'd0:    return 3'b000;   // add
            3'd1:    return 3'b001;   // sll
            3'd4:    return 3'b100;   // xor
            3'd5:    return 3'b101;   // srl
            3'd6:    return 3'b110;   // or
            default: return 3'b111;   // and
        endcase
    endfunction

    task automatic build(input logic [31:0] ins, input int fwait, input int mwait,
                         input bit rz, input int hold);
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [18:0] wb;
        bit          taken;
        op = ins[6:0];
        f3 = ins[14:12];
        wb = cw(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 0);
        for (int i = 0; i < fwait; i++)
            add_step(1, 0, coin(), ins, cw(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 0), "fetch_wait");
        add_step(1, 1, coin(), ins, cw(1, 0, 0, 1, 1, 0, 2'b00, 2'b10, 3'b000, 2'b10, 3'b000, 0), "fetch");
        add_step(1, coin(), coin(), ins,
                 cw(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 3'b000, 2'b00, (op == 7'b1101111) ? 3'b011 : 3'b010, 0), "decode");
        if (!is_legal(ins)) begin
            for (int i = 0; i < hold; i++)
                add_step(1, 1'(i % 2), coin(), ins, cw(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 1), "fault");
            add_step(0, coin(), coin(), ins, '0, "reset");
            return;
        end
        case (op)
            7'b0000011: begin
                add_step(1, coin(), coin(), ins, cw(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 3'b000, 2'b00, 3'b000, 0), "memadr_ld");
                for (int i = 0; i < mwait; i++)
                    add_step(1, 0, coin(), ins, cw(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 0), "memread_wait");
                add_step(1, 1, coin(), ins, cw(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 0), "memread");
                add_step(1, coin(), coin(), ins, cw(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000, 2'b01, 3'b000, 0), "memwb");
            end
            7'b0100011: begin
                add_step(1, coin(), coin(), ins, cw(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 3'b000, 2'b00, 3'b001, 0), "memadr_st");
                for (int i = 0; i < mwait; i++)
                    add_step(1, 0, coin(), ins, cw(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 0), "memwrite_wait");
                add_step(1, 1, coin(), ins, cw(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 0), "memwrite");
            end
            7'b0110011: begin
                add_step(1, coin(), coin(), ins, cw(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, alu_for(f3), 2'b00, 3'b000, 0), "execr");
                add_step(1, coin(), coin(), ins, wb, "aluwb");
            end
            7'b0010011: begin
                add_step(1, coin(), coin(), ins, cw(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, alu_for(f3), 2'b00, 3'b000, 0), "execi");
                add_step(1, coin(), coin(), ins, wb, "aluwb");
            end
            7'b1100011: begin
                taken = (f3 == 3'd0) ? rz : !rz;
                add_step(1, coin(), rz, ins, cw(0, 0, 0, 0, taken, 0, 2'b10, 2'b00, 3'b100, 2'b00, 3'b000, 0), "branch");
            end
            7'b1101111: begin
                add_step(1, coin(), coin(), ins, cw(0, 0, 0, 0, 1, 0, 2'b01, 2'b10, 3'b000, 2'b00, 3'b000, 0), "jal");
                add_step(1, coin(), coin(), ins, wb, "aluwb");
            end
            default: begin
                add_step(1, coin(), coin(), ins, cw(0, 0, 0, 0, 0, 0, 2'b11, 2'b01, 3'b000, 2'b00, 3'b100, 0), "lui");
                add_step(1, coin(), coin(), ins, wb, "aluwb");
            end
        endcase
    endtask

    // Each step: drive at the falling edge, compare 1 ns later, well before the next rising edge.
    task automatic run_steps();
        step_t s;
        int    n;
        n = steps.size();
        while (steps.size() > 0) begin
            s = steps.pop_front();
            @(negedge clk);
            rst_n      = s.rst_n;
            mem_ready  = s.mr;
            ResultZero = s.rz;
            instr      = s.ins;
            #1;
            check_eq($sformatf("%s@%h", s.tag, s.ins), 32'(observed), 32'(s.exp));
        end
        n_txn++;
        $display("txn %0d instr=%h cycles=%0d", n_txn, instr, n);
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] ins;
        logic [6:0]  op;
        ins = $urandom;
        case ($urandom_range(0, 8))
            0: op = 7'b0110011;
            1: op = 7'b0010011;
            2: op = 7'b0000011;
            3: op = 7'b0100011;
            4: begin
                op = 7'b1100011;
                if (coin()) ins[14:13] = 2'b00;
            end
            5: op = 7'b1101111;
            6: op = 7'b0110111;
            default: begin
                op = 7'($urandom);
                while (known_op(op)) op = 7'($urandom);
            end
        endcase
        if (op == 7'b0110011 && coin()) ins[30] = 1'b0;
        ins[6:0] = op;
        return ins;
    endfunction

    initial begin
        add_step(0, 1, 0, 32'h0, '0, "reset_init");
        add_step(0, 0, 1, 32'h0, '0, "reset_init");
        run_steps();

        build(32'h002081B3, 0, 0, 0, 0);   // add
        build(32'h0000A103, 0, 3, 0, 0);   // lw with three wait cycles
        build(32'h00208463, 0, 0, 1, 0);   // beq, taken
        build(32'h00209463, 0, 0, 1, 0);   // bne, not taken
        build(32'h0030D093, 0, 0, 0, 0);   // srli
        build(32'h4030D093, 0, 0, 0, 3);   // srai -> fault
        build(32'h40208133, 1, 0, 0, 10);  // sub -> fault, held 10 cycles
        build(32'h0000A023, 0, 2, 0, 0);   // sw, stopped mid-write below
        run_steps();

        void'(steps.pop_back());
        build(32'h0000A023, 2, 2, 0, 0);
        steps = steps[0:steps.size()-1];
        begin
            step_t tmp[$];
            tmp = steps;
            steps.delete();
            build(32'h0000A023, 0, 2, 0, 0);
            void'(steps.pop_back());
            void'(steps.pop_back());
            run_steps();
            #1 rst_n = 1'b0;
            #1 check_eq("async_reset_memwrite", 32'(observed), 32'h0);
            steps = tmp;
            steps.delete();
        end
        build(32'h0000A023, 1, 0, 0, 0);
        run_steps();

        for (int t = 0; t < 250; t++) begin
            build(gen_instr(), $urandom_range(0, 3), $urandom_range(0, 3), coin(), $urandom_range(1, 5));
            run_steps();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
